pid_err_calc_mc: RTL and testbench

PID_ERR_CALC_MC -- requirements
Module: pid_err_calc_mc

---
 rtl/pid_err_calc_mc.sv | 191 +++++++++++++++++++
 tb/tb_pid_err_calc_mc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pid_err_calc_mc.sv
// pid_err_calc_mc: per-channel PID error terms (P, clamped I, D) on one time-multiplexed datapath.
// Build option: define PID_ERR_DIFF_DERIV_EN to take D from successive errors instead of -rate.
module pid_err_calc_mc #(
  parameter int W    = 16,
  parameter int NCH  = 3,
  parameter int ILIM = 32767
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             int_clr,
  input  logic [NCH*W-1:0] tgt,
  input  logic [NCH*W-1:0] cur,
  input  logic [NCH*W-1:0] rate,
  output logic [NCH*W-1:0] err,
  output logic [NCH*W-1:0] ierr,
  output logic [NCH*W-1:0] derr,
  output logic             out_valid
);

  localparam int                  CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]       CH_LAST = CW'(NCH - 1);
  localparam logic [W-1:0]        WMAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        WMIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W+1:0] ILIM_P  = (W+2)'(ILIM);
  localparam logic signed [W+1:0] ILIM_N  = -ILIM_P;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic             out_valid_q, out_valid_d;
  logic [NCH*W-1:0] tgt_q, tgt_d, cur_q, cur_d;
  logic [W-1:0]     err_q  [NCH];
  logic [W-1:0]     err_d  [NCH];
  logic [W-1:0]     ierr_q [NCH];
  logic [W-1:0]     ierr_d [NCH];
  logic [W-1:0]     derr_q [NCH];
  logic [W-1:0]     derr_d [NCH];
  logic [W-1:0]     tgt_a  [NCH];
  logic [W-1:0]     cur_a  [NCH];
`ifdef PID_ERR_DIFF_DERIV_EN
  logic [W-1:0]     prev_e_q [NCH];
  logic [W-1:0]     prev_e_d [NCH];
  logic [W+1:0]     d_wide;
`else
  logic [NCH*W-1:0] rate_q, rate_d;
  logic [W-1:0]     rate_a [NCH];
  logic [W:0]       d_wide;
`endif

  logic [W:0]          e_wide;
  logic [W-1:0]        e_sat, d_sat, i_new, ip_ch;
  logic signed [W+1:0] i_sum;

  // Saturate a one-bit-wider value to W-bit signed range.
  function automatic logic [W-1:0] sat_w1(input logic [W:0] v);
    if (v[W] != v[W-1]) return v[W] ? WMIN : WMAX;
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_w2(input logic [W+1:0] v);
    if (v[W+1:W-1] != {3{v[W+1]}}) return v[W+1] ? WMIN : WMAX;
    return v[W-1:0];
  endfunction

  for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
    assign tgt_a[gi]          = tgt_q[gi*W +: W];
    assign cur_a[gi]          = cur_q[gi*W +: W];
    assign err[gi*W +: W]     = err_q[gi];
    assign ierr[gi*W +: W]    = ierr_q[gi];
    assign derr[gi*W +: W]    = derr_q[gi];
`ifndef PID_ERR_DIFF_DERIV_EN
    assign rate_a[gi]         = rate_q[gi*W +: W];
`endif
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;

  // Shared datapath for the channel selected by ch_q.
  always_comb begin
    e_wide = {tgt_a[ch_q][W-1], tgt_a[ch_q]} - {cur_a[ch_q][W-1], cur_a[ch_q]};
    e_sat  = sat_w1(e_wide);
    ip_ch  = ierr_q[ch_q];
    i_sum  = {{2{ip_ch[W-1]}}, ip_ch} + {{2{e_sat[W-1]}}, e_sat};
    if (i_sum > ILIM_P) begin
      i_new = ILIM_P[W-1:0];
    end else if (i_sum < ILIM_N) begin
      i_new = ILIM_N[W-1:0];
    end else begin
      i_new = i_sum[W-1:0];
    end
`ifdef PID_ERR_DIFF_DERIV_EN
    d_wide = {{2{e_sat[W-1]}}, e_sat} - {{2{prev_e_q[ch_q][W-1]}}, prev_e_q[ch_q]};
    d_sat  = sat_w2(d_wide);
`else
    d_wide = '0 - {rate_a[ch_q][W-1], rate_a[ch_q]};
    d_sat  = sat_w1(d_wide);
`endif
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    err_d   = err_q;
    ierr_d  = ierr_q;
    derr_d  = derr_q;
`ifdef PID_ERR_DIFF_DERIV_EN
    prev_e_d = prev_e_q;
`else
    rate_d   = rate_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tgt_d   = tgt;
          cur_d   = cur;
`ifndef PID_ERR_DIFF_DERIV_EN
          rate_d  = rate;
`endif
          ch_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        err_d[ch_q]  = e_sat;
        ierr_d[ch_q] = i_new;
        derr_d[ch_q] = d_sat;
`ifdef PID_ERR_DIFF_DERIV_EN
        prev_e_d[ch_q] = e_sat;
`endif
        if (ch_q == CH_LAST) begin
          ch_d    = '0;
          state_d = DONE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clear overrides any integrator update on the same edge.
    if (int_clr) begin
      for (int k = 0; k < NCH; k++) ierr_d[k] = '0;
    end
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      tgt_q       <= '0;
      cur_q       <= '0;
`ifndef PID_ERR_DIFF_DERIV_EN
      rate_q      <= '0;
`endif
      for (int k = 0; k < NCH; k++) begin
        err_q[k]  <= '0;
        ierr_q[k] <= '0;
        derr_q[k] <= '0;
`ifdef PID_ERR_DIFF_DERIV_EN
        prev_e_q[k] <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      tgt_q       <= tgt_d;
      cur_q       <= cur_d;
`ifndef PID_ERR_DIFF_DERIV_EN
      rate_q      <= rate_d;
`endif
      for (int k = 0; k < NCH; k++) begin
        err_q[k]  <= err_d[k];
        ierr_q[k] <= ierr_d[k];
        derr_q[k] <= derr_d[k];
`ifdef PID_ERR_DIFF_DERIV_EN
        prev_e_q[k] <= prev_e_d[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_pid_err_calc_mc.sv
// Directed bench for pid_err_calc_mc: expected frames queued at accept, compared at out_valid.
module tb_pid_err_calc_mc;
  localparam int W    = 16;
  localparam int NCH  = 3;
  localparam int ILIM = 20000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             int_clr = 1'b0;
  logic [NCH*W-1:0] tgt = '0, cur = '0, rate = '0;
  logic             in_ready, out_valid;
  logic [NCH*W-1:0] err, ierr, derr;

  pid_err_calc_mc #(.W(W), .NCH(NCH), .ILIM(ILIM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .int_clr(int_clr), .tgt(tgt), .cur(cur), .rate(rate),
    .err(err), .ierr(ierr), .derr(derr), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NCH*W-1:0] e;
    logic [NCH*W-1:0] i;
    logic [NCH*W-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_i[NCH];
  int   m_p[NCH];
  int   last_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [47:0] pk(input int a0, input int a1, input int a2);
    return {a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  function automatic int sl(input logic [47:0] v, input int k);
    logic [15:0] h;
    h = v[k*16 +: 16];
    return int'($signed(h));
  endfunction

  // One frame: accept, queue expected result, scramble inputs mid-RUN, then check output.
  task automatic do_frame(input logic [47:0] t, input logic [47:0] c, input logic [47:0] r,
                          input bit clr0, input bit keep, input bit spacing);
    int   n;
    int   e, ii, d;
    exp_t x;
    n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    tgt = t;
    cur = c;
    rate = r;
    @(posedge clk);
    if (spacing) chk("accept_spacing", 64'(cyc - last_acc), 64'd5);
    last_acc = cyc;
    if (clr0) for (int k = 0; k < NCH; k++) m_i[k] = 0;
    for (int k = 0; k < NCH; k++) begin
      e  = sat(sl(t, k) - sl(c, k));
      ii = m_i[k] + e;
      if (ii > ILIM) ii = ILIM;
      if (ii < -ILIM) ii = -ILIM;
      if (clr0 && k == 0) ii = 0;
      m_i[k] = ii;
`ifdef PID_ERR_DIFF_DERIV_EN
      d = sat(e - m_p[k]);
      m_p[k] = e;
`else
      d = sat(-sl(r, k));
`endif
      x.e[k*16 +: 16] = 16'(e);
      x.i[k*16 +: 16] = 16'(ii);
      x.d[k*16 +: 16] = 16'(d);
    end
    sb.push_back(x);
    n = 0;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      if (s == 1) begin
        chk("in_ready_run", 64'(in_ready), 64'd0);
        if (!keep) in_valid = 1'b0;
        int_clr = clr0;
        tgt = 48'({$urandom(), $urandom()});
        cur = 48'({$urandom(), $urandom()});
        rate = 48'({$urandom(), $urandom()});
      end else begin
        int_clr = 1'b0;
      end
      if (out_valid === 1'b1) begin
        n = s;
        break;
      end
    end
    chk("out_valid_latency", 64'(n), 64'd4);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("err", 64'(err), 64'(x.e));
      chk("ierr", 64'(ierr), 64'(x.i));
      chk("derr", 64'(derr), 64'(x.d));
      $display("frame at cycle %0d err=%h ierr=%h derr=%h", last_acc, err, ierr, derr);
    end
    @(negedge clk);
    chk("out_valid_pulse", 64'(out_valid), 64'd0);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int pulses;
    for (int k = 0; k < NCH; k++) begin
      m_i[k] = 0;
      m_p[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ierr", 64'(ierr), 64'd0);
    chk("rst_derr", 64'(derr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic frame, also exercising -(-32768) on the rate path.
    do_frame(pk(100, -50, 0), pk(40, 50, 0), pk(5, -32768, 7), 1'b0, 1'b0, 1'b0);
    chk("basic_err0", 64'(err[15:0]), 64'd60);
    chk("basic_err1", 64'(err[31:16]), 64'hFF9C);
    chk("basic_ierr1", 64'(ierr[31:16]), 64'hFF9C);
`ifndef PID_ERR_DIFF_DERIV_EN
    chk("rate_neg_min", 64'(derr[31:16]), 64'h7FFF);
`endif
    repeat (3) @(negedge clk);
    chk("hold_err", 64'(err), 64'(pk(60, -100, 0)));
    chk("hold_ierr", 64'(ierr), 64'(pk(60, -100, 0)));

    // Proportional saturation both ways.
    do_frame(pk(32767, 0, 0), pk(-32768, 0, 0), pk(0, 0, 0), 1'b0, 1'b0, 1'b0);
    chk("psat_hi", 64'(err[15:0]), 64'h7FFF);
    do_frame(pk(-32768, 0, 0), pk(1, 0, 0), pk(0, 0, 0), 1'b0, 1'b0, 1'b0);
    chk("psat_lo", 64'(err[15:0]), 64'h8000);

    // Clear while idle.
    int_clr = 1'b1;
    @(negedge clk);
    int_clr = 1'b0;
    for (int k = 0; k < NCH; k++) m_i[k] = 0;
    chk("idle_clr", 64'(ierr), 64'd0);

    // Integral clamp, then clear during RUN at ch=0.
    do_frame(pk(15000, 0, 0), pk(0, 0, 0), pk(0, 0, 0), 1'b0, 1'b0, 1'b0);
    chk("iclamp_1", 64'(ierr[15:0]), 64'd15000);
    do_frame(pk(15000, 0, 0), pk(0, 0, 0), pk(0, 0, 0), 1'b0, 1'b0, 1'b0);
    chk("iclamp_2", 64'(ierr[15:0]), 64'd20000);
    do_frame(pk(15000, 0, 0), pk(0, 0, 0), pk(0, 0, 0), 1'b1, 1'b0, 1'b0);
    chk("run_clr", 64'(ierr), 64'd0);

    // in_valid held high: one accept every NCH+2 clocks.
    do_frame(pk(1, 2, 3), pk(0, 0, 0), pk(1, 1, 1), 1'b0, 1'b1, 1'b0);
    do_frame(pk(4, 5, 6), pk(1, 1, 1), pk(2, 2, 2), 1'b0, 1'b1, 1'b1);
    do_frame(pk(-7, 8, -9), pk(3, 3, 3), pk(-3, 3, -3), 1'b0, 1'b0, 1'b1);

    // Reset during RUN at ch=1.
    in_valid = 1'b1;
    tgt = pk(11, 22, 33);
    cur = pk(0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_ierr", 64'(ierr), 64'd0);
    chk("midrst_derr", 64'(derr), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    pulses = 0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    chk("midrst_no_valid", 64'(pulses), 64'd0);
    sb.delete();
    for (int k = 0; k < NCH; k++) begin
      m_i[k] = 0;
      m_p[k] = 0;
    end

    // Derivative sequence on channel 2.
    do_frame(pk(0, 0, 10), pk(0, 0, 0), pk(0, 0, 0), 1'b0, 1'b0, 1'b0);
`ifdef PID_ERR_DIFF_DERIV_EN
    chk("dderiv_1", 64'(derr[47:32]), 64'd10);
`endif
    do_frame(pk(0, 0, 25), pk(0, 0, 0), pk(0, 0, 0), 1'b0, 1'b0, 1'b0);
`ifdef PID_ERR_DIFF_DERIV_EN
    chk("dderiv_2", 64'(derr[47:32]), 64'd15);
`endif
    chk("ierr2_accum", 64'(ierr[47:32]), 64'd35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
